line_cmd_arbiter: RTL and testbench

//   Shares one Bresenham line rasterizer between NUM_REQ command sources (e.g. CPU, sprite, UI).

---
 rtl/line_cmd_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_line_cmd_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_arbiter.sv
// Round-robin arbiter that shares one line rasterizer between NUM_REQ command sources,
// with a WAIT-state watchdog and a zero-length shortcut that bypasses the rasterizer.

module line_cmd_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               ras_draw,
  input logic               cmd_done,
  input logic               cmd_timeout
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_draw_pulse:   assert property (@(posedge clk) disable iff (reset) ras_draw |=> !ras_draw);
  a_done_pulse:   assert property (@(posedge clk) disable iff (reset) cmd_done |=> !cmd_done);
  a_timeout_done: assert property (@(posedge clk) disable iff (reset) cmd_timeout |-> cmd_done);

endmodule

module line_cmd_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CW      = 10,
  parameter  int TIMEOUT = 2048,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*CW-1:0] req_x1,
  input  logic [NUM_REQ*CW-1:0] req_y1,
  input  logic [NUM_REQ*CW-1:0] req_x2,
  input  logic [NUM_REQ*CW-1:0] req_y2,
  output logic                  ras_draw,
  output logic [CW-1:0]         ras_x1,
  output logic [CW-1:0]         ras_y1,
  output logic [CW-1:0]         ras_x2,
  output logic [CW-1:0]         ras_y2,
  input  logic                  ras_done,
  output logic                  cmd_done,
  output logic [IW-1:0]         cmd_done_id,
  output logic                  cmd_timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     id_r;
  logic [TW-1:0]     timer_r;
  logic [CW-1:0]     x1_r, y1_r, x2_r, y2_r;
  logic              ras_draw_r;
  logic              cmd_done_r;
  logic              cmd_timeout_r;
  logic              busy_r;

  logic              grant_vld_s;
  logic [IW-1:0]     grant_id_s;
  logic [CW-1:0]     sel_x1_s, sel_y1_s, sel_x2_s, sel_y2_s;
  logic              zero_len_s;
  logic              handshake_s;
  logic              timeout_hit_s;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_REQ;
    return IW'(sum);
  endfunction

  function automatic logic [CW-1:0] coord_sel(input logic [NUM_REQ*CW-1:0] vec,
                                               input logic [IW-1:0] id);
    return vec[int'(id)*CW +: CW];
  endfunction

  // Round-robin grant: walk offsets from far to near so the closest valid requester wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      grant_id_s  = req_valid[rr_index(rr_ptr_r, k)] ? rr_index(rr_ptr_r, k) : grant_id_s;
      grant_vld_s = grant_vld_s | req_valid[rr_index(rr_ptr_r, k)];
    end
  end

  // Coordinates of the currently granted requester and the zero-length test.
  always_comb begin
    sel_x1_s   = coord_sel(req_x1, grant_id_s);
    sel_y1_s   = coord_sel(req_y1, grant_id_s);
    sel_x2_s   = coord_sel(req_x2, grant_id_s);
    sel_y2_s   = coord_sel(req_y2, grant_id_s);
    zero_len_s = (sel_x1_s == sel_x2_s) && (sel_y1_s == sel_y2_s);
  end

  // Accept strobe is combinational so the handshake completes on the grant edge.
  always_comb begin
    handshake_s = (state_r == ST_IDLE) && grant_vld_s;
    req_ready   = handshake_s ? (NUM_REQ'(1'b1) << grant_id_s) : '0;
  end

  // Next-state logic; a ras_done in the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_nx_s    = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          state_nx_s = zero_len_s ? ST_RETIRE : ST_LAUNCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LAUNCH: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (ras_done) begin
          state_nx_s = ST_RETIRE;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          state_nx_s    = ST_RETIRE;
          timeout_hit_s = 1'b1;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RETIRE: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Command latch and round-robin pointer, both updated only on an accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
      id_r     <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      x2_r     <= '0;
      y2_r     <= '0;
    end else if (handshake_s) begin
      rr_ptr_r <= rr_index(grant_id_s, 1);
      id_r     <= grant_id_s;
      x1_r     <= sel_x1_s;
      y1_r     <= sel_y1_s;
      x2_r     <= sel_x2_s;
      y2_r     <= sel_y2_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
      id_r     <= id_r;
    end
  end

  // Watchdog timer: cleared while launching, counts every WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= '0;
    end else begin
      case (state_r)
        ST_LAUNCH: timer_r <= '0;
        ST_WAIT:   timer_r <= timer_r + TW'(1);
        default:   timer_r <= timer_r;
      endcase
    end
  end

  // Registered strobes, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_draw_r    <= 1'b0;
      cmd_done_r    <= 1'b0;
      cmd_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      ras_draw_r    <= (state_nx_s == ST_LAUNCH);
      cmd_done_r    <= (state_nx_s == ST_RETIRE);
      cmd_timeout_r <= timeout_hit_s;
      busy_r        <= (state_nx_s != ST_IDLE);
    end
  end

  assign ras_draw    = ras_draw_r;
  assign cmd_done    = cmd_done_r;
  assign cmd_timeout = cmd_timeout_r;
  assign cmd_done_id = id_r;
  assign busy        = busy_r;
  assign ras_x1      = x1_r;
  assign ras_y1      = y1_r;
  assign ras_x2      = x2_r;
  assign ras_y2      = y2_r;

  line_cmd_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .req_ready   (req_ready),
    .ras_draw    (ras_draw),
    .cmd_done    (cmd_done),
    .cmd_timeout (cmd_timeout)
  );

endmodule

// File: tb/tb_line_cmd_arbiter.sv
// Scoreboard bench for line_cmd_arbiter: expected retirements are queued at the
// handshake and compared when cmd_done appears.

module tb_line_cmd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CW      = 10;
  localparam int TIMEOUT = 16;
  localparam int IW      = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*CW-1:0] req_x1, req_y1, req_x2, req_y2;
  logic                  ras_draw;
  logic [CW-1:0]         ras_x1, ras_y1, ras_x2, ras_y2;
  logic                  ras_done;
  logic                  cmd_done;
  logic [IW-1:0]         cmd_done_id;
  logic                  cmd_timeout;
  logic                  busy;

  typedef struct {
    logic [IW-1:0] id;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   draw_cnt = 0;

  line_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x1      (req_x1),
    .req_y1      (req_y1),
    .req_x2      (req_x2),
    .req_y2      (req_y2),
    .ras_draw    (ras_draw),
    .ras_x1      (ras_x1),
    .ras_y1      (ras_y1),
    .ras_x2      (ras_x2),
    .ras_y2      (ras_y2),
    .ras_done    (ras_done),
    .cmd_done    (cmd_done),
    .cmd_done_id (cmd_done_id),
    .cmd_timeout (cmd_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input bit to);
    exp_t e;
    e.id = IW'(id);
    e.to = to;
    sb_q.push_back(e);
  endtask

  task automatic set_cmd(input int id, input int x1, input int y1, input int x2, input int y2);
    req_x1[id*CW +: CW] = CW'(x1);
    req_y1[id*CW +: CW] = CW'(y1);
    req_x2[id*CW +: CW] = CW'(x2);
    req_y2[id*CW +: CW] = CW'(y2);
  endtask

  // Retirement monitor: every cmd_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ras_draw === 1'b1) draw_cnt++;
    if (cmd_done === 1'b1) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_eq("sb_id", 32'(cmd_done_id), 32'(mon_e.id));
        check_eq("sb_timeout", 32'(cmd_timeout), 32'(mon_e.to));
      end
    end
  end

  // Issue one command from IDLE; wait_cyc<0 means hold ras_done low and expect the watchdog.
  task automatic do_cmd(input string tag, input int id, input int x1, input int y1,
                        input int x2, input int y2, input int wait_cyc, input bit exp_to,
                        input logic [NUM_REQ-1:0] extra_valid);
    bit zl;
    int n;
    zl = (x1 == x2) && (y1 == y2);
    set_cmd(id, x1, y1, x2, y2);
    req_valid = extra_valid | (NUM_REQ'(1) << id);
    #1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    push_exp(id, exp_to);
    @(negedge clk);
    req_valid = '0;
    if (zl) begin
      check_eq({tag, "_zl_done"}, 32'(cmd_done), 32'd1);
      check_eq({tag, "_zl_nodraw"}, 32'(ras_draw), 32'd0);
      check_eq({tag, "_zl_x1"}, 32'(ras_x1), 32'(x1));
    end else begin
      check_eq({tag, "_draw"}, 32'(ras_draw), 32'd1);
      check_eq({tag, "_x2"}, 32'(ras_x2), 32'(x2));
      check_eq({tag, "_y2"}, 32'(ras_y2), 32'(y2));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      if (wait_cyc > 0) begin
        repeat (wait_cyc) @(negedge clk);
        check_eq({tag, "_not_early"}, 32'(cmd_done), 32'd0);
        ras_done = 1'b1;
        @(negedge clk);
        ras_done = 1'b0;
        check_eq({tag, "_done"}, 32'(cmd_done), 32'd1);
      end else begin
        n = 0;
        while (cmd_done !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        check_eq({tag, "_timeout_lat"}, 32'(n), 32'(TIMEOUT + 1));
        check_eq({tag, "_timeout_flag"}, 32'(cmd_timeout), 32'd1);
      end
    end
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int order [5];
    int n;
    int d0;
    order = '{0, 1, 2, 3, 0};
    reset     = 1'b1;
    req_valid = '0;
    req_x1 = '0; req_y1 = '0; req_x2 = '0; req_y2 = '0;
    ras_done  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_draw", 32'(ras_draw), 32'd0);
    check_eq("rst_done", 32'(cmd_done), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_x1", 32'(ras_x1), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic line from requester 0; rr pointer advances to 1.
    do_cmd("t1", 0, 0, 0, 5, 3, 5, 1'b0, '0);

    // Zero-length line from requester 2 must never touch the rasterizer.
    d0 = draw_cnt;
    do_cmd("t3", 2, 7, 7, 7, 7, 0, 1'b0, '0);
    @(negedge clk);
    check_eq("t3_draw_cnt", 32'(draw_cnt), 32'(d0));

    // Watchdog expiry for requester 3; pointer wraps to 0.
    do_cmd("t4", 3, 1, 2, 3, 4, -1, 1'b1, '0);

    // All requesters valid together: strict rotation, no accept before the previous retire.
    for (int i = 0; i < NUM_REQ; i++) set_cmd(i, i + 1, 0, i + 20, 9);
    req_valid = '1;
    #1;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("t2_grant", 32'(req_ready), 32'(1) << order[j]);
      push_exp(order[j], 1'b0);
      @(negedge clk);
      if (j == 4) req_valid = '0;
      check_eq("t2_draw", 32'(ras_draw), 32'd1);
      check_eq("t2_x1", 32'(ras_x1), 32'(order[j] + 1));
      repeat (2) @(negedge clk);
      check_eq("t2_no_ready_wait", 32'(req_ready), 32'd0);
      ras_done = 1'b1;
      @(negedge clk);
      ras_done = 1'b0;
      check_eq("t2_done", 32'(cmd_done), 32'd1);
      check_eq("t2_no_ready_retire", 32'(req_ready), 32'd0);
      @(negedge clk);
    end

    // ras_done while idle is ignored.
    ras_done = 1'b1;
    @(negedge clk);
    ras_done = 1'b0;
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(cmd_done), 32'd0);
    @(negedge clk);
    check_eq("t6_done2", 32'(cmd_done), 32'd0);
    check_eq("t6_draw", 32'(ras_draw), 32'd0);

    // Reset in the middle of WAIT drops requester 1's command silently.
    set_cmd(1, 3, 3, 30, 40);
    req_valid = 4'b0010;
    #1;
    check_eq("t5_ready1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    check_eq("t5_draw", 32'(ras_draw), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_draw", 32'(ras_draw), 32'd0);
    check_eq("t5_rst_done", 32'(cmd_done), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_x2", 32'(ras_x2), 32'd0);
    check_eq("t5_rst_id", 32'(cmd_done_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_no_done", 32'(cmd_done), 32'd0);
    do_cmd("t5", 0, 2, 2, 9, 9, 3, 1'b0, 4'b0010);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
